md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
- REQ-001 MULT_CYCLES, default 5: cycles busy is held after a mult/multu start; legal range 1..31.
- REQ-002 DIV_CYCLES, default 10: cycles busy is held after a div/divu start; legal range 1..31.
- REQ-003 clk  in  1  single clock; all state changes on rising edge.
- REQ-004 reset  in  1  synchronous active-low reset; reset==0 at a rising edge resets the block.
- REQ-005 start  in  1  E-stage instruction is a mult/multu/div/divu; qualifies md_op.
- REQ-006 md_op  in  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9..15 treated as none.
- REQ-007 A  in  32  operand rs (dividend / multiplicand / mthi-mtlo source).
- REQ-008 B  in  32  operand rt (divisor / multiplier).
- REQ-009 busy  out  1  multi-cycle operation in flight; pipeline stalls md instructions while busy|start.
- REQ-010 md_hi_lo  out  32  E-stage read result for mfhi/mflo, carried down the pipe for forwarding.
- REQ-011 hi  out  32  architectural HI register.
- REQ-012 lo  out  32  architectural LO register.

Function
- REQ-013 State machine SHALL have states IDLE and RUN; a 5-bit down-counter SHALL track remaining RUN cycles.
- REQ-014 In IDLE, start==1 with md_op in 1..4 at edge N SHALL latch A, B, md_op, load the counter with MULT_CYCLES (1,2) or DIV_CYCLES (3,4), and enter RUN.
- REQ-015 busy SHALL equal (state==RUN), registered; for a start at edge N busy is 1 during exactly the cycles after edges N..N+L-1, L = selected latency.
- REQ-016 At edge N+L the block SHALL write the result to HI/LO, return to IDLE, and drop busy; new hi/lo are visible in the cycle busy first reads 0.
- REQ-017 mult: {HI,LO} SHALL equal signed 64-bit A*B; multu: unsigned 64-bit A*B.
- REQ-018 div: LO SHALL equal signed quotient truncated toward zero, HI the remainder with the dividend's sign; divu: unsigned quotient/remainder.
- REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
- REQ-020 Divide by zero (B==0) SHALL still run DIV_CYCLES with busy, then leave HI and LO unchanged.
- REQ-021 Operands SHALL be latched at start; A/B changes during RUN SHALL not affect the result.
- REQ-022 start asserted while in RUN SHALL be ignored (no restart, no counter reload); the stall logic must prevent it.
- REQ-023 start==1 with md_op outside 1..4 SHALL be ignored.
- REQ-024 mthi (md_op=7) / mtlo (md_op=8) in IDLE SHALL write A to HI / LO at the next edge; ignored in RUN.
- REQ-025 md_hi_lo SHALL be combinational: HI when md_op==5, LO when md_op==6, else 0; it reflects current register values regardless of busy.
- REQ-026 hi and lo outputs SHALL be the register contents directly, no bypass of an in-flight result.
- REQ-027 Only one write to HI/LO per edge; completion (REQ-016) cannot coincide with mthi/mtlo since those are ignored in RUN.

Reset
- REQ-028 On reset==0 at an edge: state=IDLE, counter=0, busy=0, HI=0, LO=0, latched operands=0.
- REQ-029 Reset during RUN SHALL abort the operation with no HI/LO write; busy=0 the following cycle.
- REQ-030 reset SHALL take priority over start, mthi, mtlo in the same cycle.

Verification
- REQ-031 mult A=0xFFFFFFFE (-2), B=3, default params -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- REQ-032 div A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
- REQ-033 mthi A=0x12345678 then mfhi next cycle -> md_hi_lo=0x12345678; mtlo during RUN -> LO unchanged after completion writes.
- REQ-034 div with B=0 after HI=0xAA, LO=0xBB -> busy 10 cycles, HI=0xAA, LO=0xBB.
- REQ-035 start mult, change A/B and pulse start with div at cycle 2 -> busy falls after 5 cycles, result is the original product.
- REQ-036 start div, reset==0 at cycle 4 -> busy=0 next cycle, HI=LO=0, no later write.

Source files
------------

// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// Operands are captured at start; the result lands in HI/LO after a fixed latency.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] md_hi_lo,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic signed [31:0] a_p0, b_p0;
  logic [3:0]         op_p0;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic               latch;
  logic [63:0]        result;
  logic               div_zero;

  function automatic logic [63:0] mul_s(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [63:0] ae, be, p;
    ae = {{32{a[31]}}, a};
    be = {{32{b[31]}}, b};
    p  = ae * be;
    return p;
  endfunction

  function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ae, be;
    ae = {32'd0, a};
    be = {32'd0, b};
    return ae * be;
  endfunction

  // Returns {remainder, quotient}; a zero divisor yields zero (caller skips the write).
  function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 64'd0;
    return {a % b, a / b};
  endfunction

  // Works on magnitudes so INT_MIN / -1 wraps to INT_MIN with remainder 0.
  function automatic logic [63:0] div_s(input logic signed [31:0] a, input logic signed [31:0] b);
    logic [31:0] ma, mb, q, r;
    if (b == 32'sd0) return 64'd0;
    ma = a[31] ? 32'(-a) : 32'(a);
    mb = b[31] ? 32'(-b) : 32'(b);
    q  = ma / mb;
    r  = ma % mb;
    if (a[31] ^ b[31]) q = -q;
    if (a[31]) r = -r;
    return {r, q};
  endfunction

  always_comb begin
    result = 64'd0;
    case (op_p0)
      OP_MULT:  result = mul_s(a_p0, b_p0);
      OP_MULTU: result = mul_u(a_p0, b_p0);
      OP_DIV:   result = div_s(a_p0, b_p0);
      OP_DIVU:  result = div_u(a_p0, b_p0);
      default:  result = 64'd0;
    endcase
  end

  assign div_zero = ((op_p0 == OP_DIV) || (op_p0 == OP_DIVU)) && (b_p0 == 32'sd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (md_op >= OP_MULT) && (md_op <= OP_DIVU)) begin
          latch   = 1'b1;
          state_d = RUN;
          cnt_d   = (md_op <= OP_MULTU) ? 5'(MULT_CYCLES) : 5'(DIV_CYCLES);
        end else if (md_op == OP_MTHI) begin
          hi_d = A;
        end else if (md_op == OP_MTLO) begin
          lo_d = A;
        end
      end
      RUN: begin
        if (cnt_q <= 5'd1) begin
          state_d = IDLE;
          cnt_d   = 5'd0;
          if (!div_zero) begin
            hi_d = result[63:32];
            lo_d = result[31:0];
          end
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture stage and architectural state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      a_p0    <= 32'sd0;
      b_p0    <= 32'sd0;
      op_p0   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (latch) begin
        a_p0  <= A;
        b_p0  <= B;
        op_p0 <= md_op;
      end
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    md_hi_lo = 32'd0;
    if (md_op == OP_MFHI)      md_hi_lo = hi_q;
    else if (md_op == OP_MFLO) md_hi_lo = lo_q;
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: vector table of mult/div results plus hand-written
// sequences for move-to/from, divide-by-zero, operand latching, restart and reset abort.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] md_hi_lo, hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .busy(busy), .md_hi_lo(md_hi_lo), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    A     = a;
    B     = b;
    step();
    start = 1'b0;
    md_op = 4'd0;
  endtask

  // Counts cycles with busy high, starting from the current cycle; bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 64) begin
      n++;
      step();
    end
  endtask

  int n;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    md_op = 4'd0;
    A     = 32'd0;
    B     = 32'd0;

    vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{4'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{4'd4, 32'd7,        32'd2,        32'd1,        32'd3,        10};
    vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[6] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[7] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
    vecs[8] = '{4'd4, 32'hFFFFFFF9, 32'd2,        32'd1,        32'h7FFFFFFC, 10};
    vecs[9] = '{4'd3, 32'd100,      32'd7,        32'd2,        32'd14,       10};

    step();
    step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;
    md_op = 4'd5;
    #1;
    check("rst_mfhi", md_hi_lo, 32'd0);
    md_op = 4'd0;
    step();

    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      A = 32'h5A5A5A5A;
      B = 32'h00000001;
      wait_done(n);
      check($sformatf("vec%0d_lat", i), 32'(n), 32'(vecs[i].lat));
      check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
    end

    // mthi / mfhi / mtlo / mflo
    md_op = 4'd7; A = 32'h12345678;
    step();
    md_op = 4'd5;
    #1;
    check("mfhi", md_hi_lo, 32'h12345678);
    md_op = 4'd8; A = 32'hCAFEF00D;
    step();
    md_op = 4'd6;
    #1;
    check("mflo", md_hi_lo, 32'hCAFEF00D);
    md_op = 4'd9;
    #1;
    check("mdhl_other", md_hi_lo, 32'd0);

    // divide by zero leaves HI/LO untouched
    md_op = 4'd7; A = 32'hAA;
    step();
    md_op = 4'd8; A = 32'hBB;
    step();
    start_op(4'd3, 32'd50, 32'd0);
    wait_done(n);
    check("div0_lat", 32'(n), 32'd10);
    check("div0_hi", hi, 32'hAA);
    check("div0_lo", lo, 32'hBB);

    // mtlo / mthi during RUN are ignored
    start_op(4'd1, 32'd2, 32'd3);
    md_op = 4'd8; A = 32'hDEAD;
    step();
    md_op = 4'd7;
    step();
    md_op = 4'd0;
    wait_done(n);
    check("mtrun_hi", hi, 32'd0);
    check("mtrun_lo", lo, 32'd6);

    // start during RUN with new operands is ignored
    start_op(4'd1, 32'd5, 32'd6);
    check("rst35_b1", {31'd0, busy}, 32'd1);
    step();
    check("rst35_b2", {31'd0, busy}, 32'd1);
    start = 1'b1; md_op = 4'd3; A = 32'd100; B = 32'd100;
    step();
    start = 1'b0; md_op = 4'd0;
    wait_done(n);
    check("restart_lat", 32'(n + 2), 32'd5);
    check("restart_hi", hi, 32'd0);
    check("restart_lo", lo, 32'd30);

    // start qualified only for ops 1..4
    start = 1'b1; md_op = 4'd5; A = 32'd9; B = 32'd9;
    step();
    start = 1'b0; md_op = 4'd0;
    check("badop_busy", {31'd0, busy}, 32'd0);
    check("badop_lo", lo, 32'd30);

    // reset aborts an in-flight divide
    start_op(4'd3, 32'd100, 32'd7);
    step();
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    for (int k = 0; k < 15; k++) step();
    check("abort_late_hi", hi, 32'd0);
    check("abort_late_lo", lo, 32'd0);

    // reset wins over mthi
    md_op = 4'd7; A = 32'h77; reset = 1'b0;
    step();
    reset = 1'b1; md_op = 4'd0;
    check("rstprio_hi", hi, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
